// File: rtl/timing_sequencer_if.sv
// Handshake/bus bundle between the timing sequencer and the CPU control unit.
// The step line exists only when SEQ_STEP_EN is defined.
interface timing_sequencer_if;
  localparam int unsigned NBEAT = 8;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 16;

  logic              run;
  logic              halt_req;
  logic [OP_W-1:0]   opcode;
`ifdef SEQ_STEP_EN
  logic              step;
`endif
  logic [NBEAT-1:0]  t;
  logic              ld;
  logic              add;
  logic              sub;
  logic              and_op;
  logic              or_op;
  logic              busy;
  logic              illegal;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
`ifdef SEQ_STEP_EN
    output step,
`endif
    output run, halt_req, opcode,
    input  t, ld, add, sub, and_op, or_op, busy, illegal, instr_cnt
  );

  modport slave (
`ifdef SEQ_STEP_EN
    input  step,
`endif
    input  run, halt_req, opcode,
    output t, ld, add, sub, and_op, or_op, busy, illegal, instr_cnt
  );
endinterface

// File: rtl/timing_sequencer.sv
// Beat generator, opcode decoder, run/halt control and retired-instruction counter.
// Optional single-step start is enabled by defining SEQ_STEP_EN.
module timing_sequencer #(
  parameter int unsigned LAST_BEAT = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  timing_sequencer_if.slave   sif_io
);
  localparam int unsigned NBEAT = 8;
  localparam int unsigned DEC_W = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [2:0]  LAST_IDX = 3'(LAST_BEAT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [NBEAT-1:0] t_q, t_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic             ill_q, ill_d;
  logic             halt_q, halt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic step_c;
  logic halt_c;
  logic go_c;
  logic start_c;

`ifdef SEQ_STEP_EN
  assign step_c = sif_io.step;
`else
  assign step_c = 1'b0;
`endif

  // A halt request in the boundary cycle itself already blocks the restart.
  assign halt_c  = halt_q | sif_io.halt_req;
  assign go_c    = sif_io.run & ~halt_c & ~ill_q;
  assign start_c = (sif_io.run | step_c) & ~halt_c & ~ill_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      dec_q   <= '0;
      ill_q   <= 1'b0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      dec_q   <= dec_d;
      ill_q   <= ill_d;
      halt_q  <= halt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dec_d   = dec_q;
    ill_d   = ill_q;
    halt_d  = halt_c;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        halt_d = sif_io.halt_req;
        dec_d  = '0;
        if (start_c) begin
          state_d = S_EXEC;
          t_d     = NBEAT'(1);
        end
      end
      S_EXEC: begin
        if (t_q[LAST_IDX]) begin
          cnt_d = cnt_q + CNT_W'(1);
          dec_d = '0;
          if (go_c) begin
            t_d = NBEAT'(1);
          end else begin
            state_d = S_IDLE;
            t_d     = '0;
            halt_d  = 1'b0;
          end
        end else begin
          t_d = t_q << 1;
          // End of T2: latch the opcode into the one-hot decode lines.
          if (t_q[2]) begin
            case (sif_io.opcode)
              3'd0:    dec_d = DEC_W'(5'b00001);
              3'd1:    dec_d = DEC_W'(5'b00010);
              3'd2:    dec_d = DEC_W'(5'b00100);
              3'd3:    dec_d = DEC_W'(5'b01000);
              3'd4:    dec_d = DEC_W'(5'b10000);
              default: begin
                dec_d = '0;
                ill_d = 1'b1;
              end
            endcase
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
        dec_d   = '0;
      end
    endcase
    busy_d = |t_d;
  end

  assign sif_io.t         = t_q;
  assign sif_io.ld        = dec_q[0];
  assign sif_io.add       = dec_q[1];
  assign sif_io.sub       = dec_q[2];
  assign sif_io.and_op    = dec_q[3];
  assign sif_io.or_op     = dec_q[4];
  assign sif_io.busy      = busy_q;
  assign sif_io.illegal   = ill_q;
  assign sif_io.instr_cnt = cnt_q;
endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: an 8-beat instance and a 5-beat instance.
module tb_timing_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  timing_sequencer_if sif ();
  timing_sequencer_if sif4 ();

  timing_sequencer #(.LAST_BEAT(7)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .sif_io (sif)
  );

  timing_sequencer #(.LAST_BEAT(4)) u_dut4 (
    .clk_i  (clk),
    .rst_i  (rst),
    .sif_io (sif4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input string tag, input logic [7:0] et, input logic [4:0] ed,
                      input logic eb, input logic ei, input logic [15:0] ec);
    chk({tag, ".t"},    32'(sif.t), 32'(et));
    chk({tag, ".dec"},  32'({sif.or_op, sif.and_op, sif.sub, sif.add, sif.ld}), 32'(ed));
    chk({tag, ".busy"}, 32'(sif.busy), 32'(eb));
    chk({tag, ".ill"},  32'(sif.illegal), 32'(ei));
    chk({tag, ".cnt"},  32'(sif.instr_cnt), 32'(ec));
  endtask

  task automatic snap4(input string tag, input logic [7:0] et, input logic [4:0] ed,
                       input logic eb, input logic ei, input logic [15:0] ec);
    chk({tag, ".t"},    32'(sif4.t), 32'(et));
    chk({tag, ".dec"},  32'({sif4.or_op, sif4.and_op, sif4.sub, sif4.add, sif4.ld}), 32'(ed));
    chk({tag, ".busy"}, 32'(sif4.busy), 32'(eb));
    chk({tag, ".ill"},  32'(sif4.illegal), 32'(ei));
    chk({tag, ".cnt"},  32'(sif4.instr_cnt), 32'(ec));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sif.run = 1'b0;  sif.halt_req = 1'b0;  sif.opcode = 3'd0;
    sif4.run = 1'b0; sif4.halt_req = 1'b0; sif4.opcode = 3'd0;
`ifdef SEQ_STEP_EN
    sif.step = 1'b0;
    sif4.step = 1'b0;
`endif
    tick();
    tick();
    snap("reset", 8'h00, 5'd0, 1'b0, 1'b0, 16'd0);
    snap4("reset4", 8'h00, 5'd0, 1'b0, 1'b0, 16'd0);

    // First LD instruction, one-hot sweep T0..T7
    rst = 1'b0;
    sif.run = 1'b1;
    tick();
    snap("ld_t0", 8'h01, 5'd0, 1'b1, 1'b0, 16'd0);
    for (int b = 1; b < 8; b++) begin
      tick();
      snap($sformatf("ld_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00001 : 5'd0, 1'b1, 1'b0, 16'd0);
    end
    tick();
    snap("ld_next", 8'h01, 5'd0, 1'b1, 1'b0, 16'd1);

    // ADD, SUB, AND, OR back to back
    for (int op = 1; op <= 4; op++) begin
      sif.opcode = 3'(op);
      for (int b = 1; b < 8; b++) begin
        tick();
        snap($sformatf("op%0d_t%0d", op, b), 8'(1 << b), (b >= 3) ? 5'(1 << op) : 5'd0,
             1'b1, 1'b0, 16'(op));
      end
      tick();
      snap($sformatf("op%0d_next", op), 8'h01, 5'd0, 1'b1, 1'b0, 16'(op + 1));
    end

    // Halt request during T4
    sif.opcode = 3'd0;
    for (int b = 1; b < 8; b++) begin
      tick();
      snap($sformatf("halt_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00001 : 5'd0, 1'b1, 1'b0, 16'd5);
      sif.halt_req = (b == 4);
    end
    tick();
    snap("halt_idle", 8'h00, 5'd0, 1'b0, 1'b0, 16'd6);
    tick();
    snap("halt_restart", 8'h01, 5'd0, 1'b1, 1'b0, 16'd6);

    // Illegal opcode 110
    sif.opcode = 3'd6;
    for (int b = 1; b < 8; b++) begin
      tick();
      snap($sformatf("ill_t%0d", b), 8'(1 << b), 5'd0, 1'b1, (b >= 3), 16'd6);
    end
    sif.opcode = 3'd0;
    tick();
    snap("ill_idle", 8'h00, 5'd0, 1'b0, 1'b1, 16'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      snap($sformatf("ill_stay%0d", k), 8'h00, 5'd0, 1'b0, 1'b1, 16'd7);
    end

    // Reset clears ILLEGAL, then a full instruction, then reset during T5
    rst = 1'b1;
    tick();
    snap("rst_clear", 8'h00, 5'd0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    snap("rst_t0", 8'h01, 5'd0, 1'b1, 1'b0, 16'd0);
    for (int b = 1; b < 8; b++) begin
      tick();
      snap($sformatf("rst_a_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00001 : 5'd0, 1'b1, 1'b0, 16'd0);
    end
    tick();
    snap("rst_b_t0", 8'h01, 5'd0, 1'b1, 1'b0, 16'd1);
    for (int b = 1; b < 6; b++) begin
      tick();
      snap($sformatf("rst_b_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00001 : 5'd0, 1'b1, 1'b0, 16'd1);
    end
    rst = 1'b1;
    tick();
    snap("rst_mid", 8'h00, 5'd0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    snap("rst_resume", 8'h01, 5'd0, 1'b1, 1'b0, 16'd0);

    // RUN falls during T3: instruction completes, then idle
    for (int b = 1; b < 8; b++) begin
      tick();
      snap($sformatf("runlo_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00001 : 5'd0, 1'b1, 1'b0, 16'd0);
      if (b == 3) sif.run = 1'b0;
    end
    tick();
    snap("runlo_idle", 8'h00, 5'd0, 1'b0, 1'b0, 16'd1);
    tick();
    snap("runlo_stay", 8'h00, 5'd0, 1'b0, 1'b0, 16'd1);
    sif.run = 1'b1;
    tick();
    snap("runhi_t0", 8'h01, 5'd0, 1'b1, 1'b0, 16'd1);

    // Halt request in the final beat takes effect at that boundary
    for (int b = 1; b < 8; b++) begin
      tick();
      snap($sformatf("hlast_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00001 : 5'd0, 1'b1, 1'b0, 16'd1);
      sif.halt_req = (b == 7);
    end
    tick();
    snap("hlast_idle", 8'h00, 5'd0, 1'b0, 1'b0, 16'd2);
    sif.halt_req = 1'b0;
    tick();
    snap("hlast_restart", 8'h01, 5'd0, 1'b1, 1'b0, 16'd2);
    sif.run = 1'b0;

    // Five-beat instance: T5..T7 never asserted
    sif4.run = 1'b1;
    sif4.opcode = 3'd1;
    tick();
    snap4("lb4_t0", 8'h01, 5'd0, 1'b1, 1'b0, 16'd0);
    for (int b = 1; b < 5; b++) begin
      tick();
      snap4($sformatf("lb4_a_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00010 : 5'd0, 1'b1, 1'b0, 16'd0);
    end
    tick();
    snap4("lb4_next", 8'h01, 5'd0, 1'b1, 1'b0, 16'd1);
    sif4.run = 1'b0;
    for (int b = 1; b < 5; b++) begin
      tick();
      snap4($sformatf("lb4_b_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00010 : 5'd0, 1'b1, 1'b0, 16'd1);
    end
    tick();
    snap4("lb4_idle", 8'h00, 5'd0, 1'b0, 1'b0, 16'd2);
    tick();
    snap("main_idle", 8'h00, 5'd0, 1'b0, 1'b0, 16'd3);

`ifdef SEQ_STEP_EN
    // Single STEP pulse with RUN=0 runs exactly one instruction
    sif4.step = 1'b1;
    tick();
    sif4.step = 1'b0;
    snap4("step_t0", 8'h01, 5'd0, 1'b1, 1'b0, 16'd2);
    for (int b = 1; b < 5; b++) begin
      tick();
      snap4($sformatf("step_t%0d", b), 8'(1 << b), (b >= 3) ? 5'b00010 : 5'd0, 1'b1, 1'b0, 16'd2);
    end
    tick();
    snap4("step_idle", 8'h00, 5'd0, 1'b0, 1'b0, 16'd3);
    tick();
    snap4("step_stay", 8'h00, 5'd0, 1'b0, 1'b0, 16'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Beat generator and instruction-phase controller for the CPU model. It produces the one-hot machine-cycle beats T0..T7 and latches and decodes the opcode into the one-hot LD/ADD/SUB/AND/OR lines. Both sets of signals drive the combinational control unit directly. It also handles run/halt, stops on illegal opcodes, and counts retired instructions.

## Interface
- LAST_BEAT, 7, index of final beat per instruction; legal 3..7. Beats above LAST_BEAT are never asserted.
- CLK  in  1  rising-edge clock for all state.
- RST  in  1  synchronous, active-high reset.
- RUN  in  1  level; 1 = execute continuously, 0 = stop at the next instruction boundary.
- HALT_REQ  in  1  single-cycle pulse; sets the sticky halt-pending flag.
- OPCODE  in  3  opcode field from IR; sampled during T2.
- STEP  in  1  present only with SEQ_STEP_EN; single-cycle pulse.
- T0..T7  out  1 each  one-hot beat; all 0 when idle.
- LD, ADD, SUB, AND, OR  out  1 each  registered one-hot decode.
- BUSY  out  1  high whenever any T is high.
- ILLEGAL  out  1  sticky illegal-opcode flag.
- INSTR_CNT  out  16  retired-instruction counter.

## Operation
- Two states: IDLE (beat vector all 0) and EXEC (exactly one T high).
- IDLE -> EXEC on the first edge that sees RUN=1, HALT pending=0 and ILLEGAL=0. T0 asserts after that edge.
- In EXEC the beat advances T(n) -> T(n+1) every cycle up to T(LAST_BEAT). No stalls.
- Leaving T(LAST_BEAT):
  - if RUN=1, HALT pending=0 and ILLEGAL=0 -> T0 on the next cycle (back-to-back, no gap);
  - otherwise -> IDLE.
- Opcode decode:
  - The edge ending T2 latches OPCODE: 000 LD, 001 ADD, 010 SUB, 011 AND, 100 OR.
  - 101..111 leave all decode outputs at 0 and set ILLEGAL at the same edge.
  - Decode outputs hold from T3 through T(LAST_BEAT). They clear to 0 at the edge entering T0 or IDLE.
  - During T0..T2 all decode outputs are 0 (common fetch phase).
- HALT_REQ:
  - Sets the pending flag at any time, including in IDLE.
  - The flag stops the sequencer only at an instruction boundary; the current instruction always completes.
  - The flag clears when the sequencer enters IDLE; if asserted in IDLE, it clears at the next edge.
- RUN falling mid-instruction: the instruction completes, then the sequencer goes to IDLE.
- ILLEGAL is sticky until RST. The illegal instruction runs to T(LAST_BEAT) with no decode line active, then the sequencer goes to IDLE and does not restart.
- INSTR_CNT increments at every edge leaving T(LAST_BEAT), illegal instructions included. It wraps 0xFFFF -> 0x0000.
- HALT_REQ and the T(LAST_BEAT) edge in the same cycle: the halt takes effect at that boundary.

## Timing
- Reset values: T0..T7=0, all decode outputs=0, BUSY=0, ILLEGAL=0, INSTR_CNT=0, halt pending=0.
- RST mid-instruction: every output is at its reset value after that edge. The instruction is abandoned and not counted.
- Start latency: one edge from the sampled RUN=1 to T0 high.
- Instruction length: LAST_BEAT+1 cycles. Instruction k+1 starts with T0 in the cycle immediately after T(LAST_BEAT) of instruction k.
- Decode latency: OPCODE sampled at the end of T2; LD..OR valid from the first cycle of T3.
- Outputs are registered only, with no combinational path from inputs to outputs.

## Configuration
- SEQ_STEP_EN defined:
  - STEP port exists.
  - In IDLE, STEP=1 starts exactly one instruction regardless of RUN, as long as HALT pending=0 and ILLEGAL=0. At T(LAST_BEAT) the sequencer returns to IDLE unless RUN=1.
  - STEP is ignored in EXEC.
- SEQ_STEP_EN undefined: no STEP port; only RUN starts execution.

## Test plan
- RST, then RUN=1 held, OPCODE=000 -> T0..T7 one-hot over 8 cycles. LD=1 only during T3..T7. INSTR_CNT=1 after the T7 edge, and T0 follows immediately.
- OPCODE sequence 001, 010, 011, 100 across four back-to-back instructions -> ADD, SUB, AND, OR respectively during T3..T7. INSTR_CNT=4. No idle gap between instructions.
- HALT_REQ pulse during T4 -> beats continue to T7, then all T=0 and BUSY=0. INSTR_CNT is incremented once. Restarting requires a fresh RUN sample.
- OPCODE=110 at T2 -> ILLEGAL=1 from T3, no decode line active. The sequencer goes idle after T7 and stays idle with RUN=1.
- RST asserted during T5 -> next cycle all outputs 0 and INSTR_CNT=0. With RUN still 1, T0 follows one edge after RST deasserts.
- LAST_BEAT=4, INSTR_CNT preset by running 0xFFFF instructions -> T5..T7 never asserted, 5-cycle instructions, counter wraps to 0x0000. With SEQ_STEP_EN and RUN=0, a STEP pulse yields exactly one 5-cycle instruction.
